serial_bit_tx: RTL and testbench

Parallel-to-serial transmitter that produces the single-bit `en`/`din` stream consumed by the enabled flip-flop and shift-register receivers in this design. It accepts one WIDTH-bit word per valid/ready handshake and presents it bit by bit on `dout`, with a one-cycle `en` strobe per bit. The strobe is placed at the end of each bit period, so a downstream enabled flop samples stable data. It sits between word-level producers (counters, test pattern sources) and bit-serial sinks.

---
 rtl/serial_pkg.sv | 25 ++
 rtl/serial_bit_tx_tick.sv | 47 ++++
 rtl/serial_bit_tx.sv | 145 ++++++++++++++
 tb/tb_serial_bit_tx.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg
// Shared definitions for the bit-serial transmit path and its matching
// receivers. A receiver built against these defaults sees the same word
// width and bit period as the transmitter.
//   tx_state_t    : transmitter FSM states
//   DEFAULT_WIDTH : bits per word
//   DEFAULT_DIV   : clock cycles per bit period
//   cnt_width()   : counter width for a 0..n-1 counter, never below 1 bit
package serial_pkg;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } tx_state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DIV   = 4;

  // A counter that must reach n-1 needs $clog2(n) bits. n==1 would give
  // zero bits, so it is clamped to a single bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_bit_tx_tick.sv
// bit_tick_gen
// Bit-period divider for the serial transmitter. While run is high the
// counter steps through 0..DIV-1 and wraps. tick flags the final count of
// each period. Dropping run clears the counter, so every word starts from
// a fresh period.
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   run   : count enable; the counter is held at zero while low
//   tick  : high while the count equals DIV-1
module bit_tick_gen
  import serial_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int            CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // The next count wraps on the terminal value and returns to zero
  // whenever the transmitter is not actively timing a bit.
  always_comb begin
    cnt_d = '0;
    if (run && !tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Period counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_bit_tx.sv
// serial_bit_tx
// Parallel-to-serial transmitter. It takes one WIDTH-bit word per
// valid/ready handshake and plays it out on dout, one bit every DIV
// cycles. en pulses in the last cycle of each bit period, so a
// downstream enabled flop captures data that has been stable for the
// whole period. done accompanies the final strobe.
//   clk      : rising-edge clock
//   reset    : synchronous, active-high reset
//   in_valid : producer offers in_data
//   in_data  : word to send, captured only on the handshake
//   in_ready : idle and able to accept a word (low while reset is high)
//   dout     : current serial bit (registered)
//   en       : bit strobe, one cycle at the end of each bit (registered)
//   busy     : word in flight
//   done     : one-cycle pulse alongside the last strobe (registered)
module serial_bit_tx
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DIV       = DEFAULT_DIV,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             dout,
  output logic             en,
  output logic             busy,
  output logic             done
);

  localparam int            BW       = cnt_width(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             dout_q, dout_d;
  logic             en_q, en_d;
  logic             done_q, done_d;

  logic             handshake;
  logic             run;
  logic             tick;
  logic [BW-1:0]    bit_base;
  logic [WIDTH-1:0] shift_next;

  function automatic logic head_of(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // The strobe and done are registered, so they are decided one cycle
  // ahead from the divider tick. The divider therefore runs from the
  // handshake cycle through the cycle that decides the last strobe. It
  // stops in the done cycle so the next word starts with a cleared count.
  assign handshake = (state_q == S_IDLE) && in_valid && in_ready;
  assign run       = handshake || ((state_q == S_SHIFT) && !done_q);
  assign bit_base  = handshake ? '0 : bit_cnt_q;
  assign shift_next = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);

  assign in_ready = (state_q == S_IDLE) && !reset;
  assign busy     = (state_q == S_SHIFT);
  assign dout     = dout_q;
  assign en       = en_q;
  assign done     = done_q;

  bit_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .tick  (tick)
  );

  // Next-state logic. dout always shows the head of the shift register
  // during a transfer. The register advances on the edge that ends a
  // strobe cycle, which moves the next bit onto dout for the following
  // period. bit_cnt counts strobes that have been scheduled, so the last
  // one can be flagged as done.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_base;
    dout_d    = dout_q;
    en_d      = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        dout_d = 1'b0;
        if (handshake) begin
          shift_d = in_data;
          dout_d  = head_of(in_data);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (done_q) begin
          state_d = S_IDLE;
          dout_d  = 1'b0;
        end else if (en_q) begin
          shift_d = shift_next;
          dout_d  = head_of(shift_next);
        end
      end
      default: begin
        state_d = S_IDLE;
        dout_d  = 1'b0;
      end
    endcase

    if (run && tick) begin
      en_d = 1'b1;
      if (bit_base == BIT_LAST) begin
        done_d    = 1'b1;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_base + 1'b1;
      end
    end
  end

  // State and output registers. Reset abandons any word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      dout_q    <= 1'b0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      dout_q    <= dout_d;
      en_q      <= en_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_bit_tx.sv
// tb_serial_bit_tx
// Directed bench for serial_bit_tx. Three instances cover MSB-first and
// LSB-first at DIV=4 plus MSB-first at DIV=1. Each one gets its own
// in_valid, while clock, reset and in_data are shared. Expected outputs
// for every cycle of a transfer are derived from the word and the cycle
// index alone.
module tb_serial_bit_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] inValid;
  logic [7:0] inData;
  logic [2:0] inReady, dout, en, busy, done;

  int vectorCount = 0;
  int missCount   = 0;
  int cycleNum    = 0;
  int lastHs      = 0;

  always #5 clk = ~clk;

  // Free-running edge counter used to measure handshake spacing.
  always @(posedge clk) cycleNum <= cycleNum + 1;

  serial_bit_tx #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b1)) dutMsb (
    .clk(clk), .reset(reset), .in_valid(inValid[0]), .in_data(inData),
    .in_ready(inReady[0]), .dout(dout[0]), .en(en[0]), .busy(busy[0]), .done(done[0])
  );

  serial_bit_tx #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b0)) dutLsb (
    .clk(clk), .reset(reset), .in_valid(inValid[1]), .in_data(inData),
    .in_ready(inReady[1]), .dout(dout[1]), .en(en[1]), .busy(busy[1]), .done(done[1])
  );

  serial_bit_tx #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1)) dutFast (
    .clk(clk), .reset(reset), .in_valid(inValid[2]), .in_data(inData),
    .in_ready(inReady[2]), .dout(dout[2]), .en(en[2]), .busy(busy[2]), .done(done[2])
  );

  // Single comparison point: counts the vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Packed view {in_ready, busy, en, dout, done} of one instance.
  function automatic logic [4:0] obs(input int s);
    return {inReady[s], busy[s], en[s], dout[s], done[s]};
  endfunction

  // Expected packed view for cycle c after the handshake of an 8-bit word.
  function automatic logic [4:0] expVec(input int c, input int div, input bit msbFirst,
                                        input logic [7:0] word);
    int   n;
    int   k;
    logic b;
    n = 8 * div;
    b = 1'b0;
    if (c <= n) begin
      k = (c - 1) / div;
      b = msbFirst ? word[7 - k] : word[k];
    end
    return {(c == n + 1), (c <= n), ((c % div == 0) && (c <= n)), b, (c == n)};
  endfunction

  // Offers a word from an idle negedge and checks every cycle until the
  // block is ready again. keepValid leaves in_valid asserted after the
  // handshake, and dataAfter replaces in_data once the word is taken.
  task automatic applyStimulus(input string tag, input int s, input int div, input bit msbFirst,
                               input logic [7:0] word, input bit keepValid,
                               input logic [7:0] dataAfter);
    int n;
    n = 8 * div;
    checkOutput({tag, "_ready0"}, 32'(inReady[s]), 32'd1);
    inValid[s] = 1'b1;
    inData     = word;
    for (int c = 1; c <= n + 1; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1) lastHs = cycleNum;
      checkOutput($sformatf("%s_c%0d", tag, c), 32'(obs(s)), 32'(expVec(c, div, msbFirst, word)));
      if (c == 1) begin
        inValid[s] = keepValid;
        inData     = dataAfter;
      end
    end
  endtask

  initial begin
    int t1;
    reset   = 1'b1;
    inValid = 3'b000;
    inData  = 8'h00;

    // Reset values, with in_ready held low while reset is asserted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) checkOutput($sformatf("rst_hold%0d", s), 32'(obs(s)), 32'h00);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) checkOutput($sformatf("rst_rel%0d", s), 32'(obs(s)), 32'h10);

    // Basic word in both bit orders, a single-one word, and DIV=1.
    applyStimulus("msb_a5", 0, 4, 1'b1, 8'hA5, 1'b0, 8'h00);
    applyStimulus("lsb_a5", 1, 4, 1'b0, 8'hA5, 1'b0, 8'h00);
    applyStimulus("lsb_01", 1, 4, 1'b0, 8'h01, 1'b0, 8'h00);
    applyStimulus("fast_f0", 2, 1, 1'b1, 8'hF0, 1'b0, 8'h00);

    // in_valid held across two words; handshakes must be 33 cycles apart.
    applyStimulus("hold_3c", 0, 4, 1'b1, 8'h3C, 1'b1, 8'hC3);
    t1 = lastHs;
    applyStimulus("hold_c3", 0, 4, 1'b1, 8'hC3, 1'b0, 8'h00);
    checkOutput("hs_gap", 32'(lastHs - t1), 32'd33);

    // in_data dropping to zero after the handshake must not leak in.
    applyStimulus("keep_ff", 0, 4, 1'b1, 8'hFF, 1'b0, 8'h00);

    // Reset at cycle 10 of a transfer aborts it.
    inValid[0] = 1'b1;
    inData     = 8'hFF;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("abort_c%0d", c), 32'(obs(0)), 32'(expVec(c, 4, 1'b1, 8'hFF)));
      if (c == 1) inValid[0] = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_rst", 32'(obs(0)), 32'h00);
    reset = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("abort_idle%0d", c), 32'(obs(0)), 32'h10);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
